// File: rtl/timer_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_param_ctrl
// Purpose  : Programmable countdown timer and parameter store for the
//            anti-theft controller. Holds four 4-bit time parameters
//            (arm, driver door, passenger door, alarm on), generates the
//            1 Hz enable, and counts a selected parameter down to zero,
//            pulsing expired when it gets there.
// Ports    : clock          - system clock, rising edge
//            reset          - synchronous active-high reset
//            reprogram      - write time_value into param[time_param_sel]
//            time_param_sel - parameter index for write and readback
//            time_value     - value to write (seconds)
//            start_timer    - load param[interval] and start counting
//            interval       - parameter index used at start
//            expired        - one-cycle pulse when the countdown ends
//            one_hz_enable  - one-cycle pulse every CLK_HZ cycles
//            busy           - countdown running
//            count          - remaining seconds, 0 when idle
//            param_rd       - combinational readback of param[time_param_sel]
// Revision : 1.0 - initial release
// ============================================================================
module timer_param_ctrl #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       start_timer,
  input  logic [1:0] interval,
  output logic       expired,
  output logic       one_hz_enable,
  output logic       busy,
  output logic [3:0] count,
  output logic [3:0] param_rd
);

  localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);

  localparam logic [3:0] DEF_ARM       = 4'd6;
  localparam logic [3:0] DEF_DRIVER    = 4'd8;
  localparam logic [3:0] DEF_PASSENGER = 4'd15;
  localparam logic [3:0] DEF_ALARM_ON  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [3:0]    count_q, count_d;
  logic          busy_q, busy_d;
  logic          expired_q, expired_d;
  logic [3:0]    param_q [4];

  logic          w_tick;
  logic [3:0]    w_load_val;

  // The tick is masked during reset so no downstream logic sees a stray
  // second boundary while the block is being cleared.
  assign w_tick        = (prescaler_q == PRE_MAX) && !reset;
  assign w_load_val    = param_q[interval];

  assign one_hz_enable = w_tick;
  assign expired       = expired_q;
  assign busy          = busy_q;
  assign count         = count_q;
  assign param_rd      = param_q[time_param_sel];

  // --------------------------------------------------------------------------
  // Parameter store
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      param_q[0] <= DEF_ARM;
      param_q[1] <= DEF_DRIVER;
      param_q[2] <= DEF_PASSENGER;
      param_q[3] <= DEF_ALARM_ON;
    end else if (reprogram) begin
      param_q[time_param_sel] <= time_value;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: reprogram > start_timer > tick.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    busy_d      = busy_q;
    expired_d   = 1'b0;
    prescaler_d = w_tick ? '0 : prescaler_q + 1'b1;

    if (reprogram) begin
      // A write always aborts a countdown silently.
      state_d = ST_IDLE;
      count_d = 4'd0;
      busy_d  = 1'b0;
    end else if (start_timer) begin
      // Restarting the prescaler makes the first second a full period.
      prescaler_d = '0;
      if (w_load_val != 4'd0) begin
        state_d = ST_RUN;
        count_d = w_load_val;
        busy_d  = 1'b1;
      end else begin
        // Zero-length interval expires immediately; the gate on expired_q
        // keeps back-to-back pulses separated by a low cycle.
        state_d   = ST_IDLE;
        count_d   = 4'd0;
        busy_d    = 1'b0;
        expired_d = !expired_q;
      end
    end else if (state_q == ST_RUN && w_tick) begin
      if (count_q > 4'd1) begin
        count_d = count_q - 4'd1;
      end else begin
        state_d   = ST_IDLE;
        count_d   = 4'd0;
        busy_d    = 1'b0;
        expired_d = !expired_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prescaler_q <= '0;
      count_q     <= 4'd0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
    end
  end

endmodule
`default_nettype wire
